// File: rtl/serial_pe_ctrl_pkg.sv
// Shared types and constants for the serial PE sequencer.
// Covers the FSM state encoding, the pe_ctl bit positions and the operand/result widths.
package serial_pe_ctrl_pkg;

  localparam int OPND_W       = 16;
  localparam int RES_W        = 32;
  localparam int PE_CTL_W     = 2;
  localparam int PE_CTL_FIRST = 0;
  localparam int PE_CTL_LAST  = 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    WAIT_SLOT,
    FIN
  } state_t;

endpackage

// File: rtl/serial_pe_ctrl_if.sv
// Bundle of the launch controls, buffer read ports, PE link and result handshake.
// The master modport is the sequencer; the slave modport is its environment.
interface serial_pe_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int VEC_W  = 8
) ();
  import serial_pe_ctrl_pkg::*;

  logic                start;
  logic [LEN_W-1:0]    vec_len;
  logic [VEC_W-1:0]    num_vec;
  logic                n_rd_en;
  logic [ADDR_W-1:0]   n_addr;
  logic [OPND_W-1:0]   n_rdata;
  logic                w_rd_en;
  logic [ADDR_W-1:0]   w_addr;
  logic [OPND_W-1:0]   w_rdata;
  logic [OPND_W-1:0]   pe_neuron;
  logic [OPND_W-1:0]   pe_weight;
  logic                pe_vld;
  logic [PE_CTL_W-1:0] pe_ctl;
  logic [RES_W-1:0]    pe_result;
  logic                pe_vld_o;
  logic [RES_W-1:0]    res;
  logic                res_vld;
  logic                res_rdy;
  logic                busy;
  logic                done;

  modport master (
    input  start, vec_len, num_vec, n_rdata, w_rdata, pe_result, pe_vld_o, res_rdy,
    output n_rd_en, n_addr, w_rd_en, w_addr, pe_neuron, pe_weight, pe_vld, pe_ctl,
           res, res_vld, busy, done
  );

  modport slave (
    output start, vec_len, num_vec, n_rdata, w_rdata, pe_result, pe_vld_o, res_rdy,
    input  n_rd_en, n_addr, w_rd_en, w_addr, pe_neuron, pe_weight, pe_vld, pe_ctl,
           res, res_vld, busy, done
  );

endinterface

// File: rtl/serial_pe_ctrl_addr_gen.sv
// Element/row counters and the weight-row base address for one matrix-vector run.
// Also produces the first/last flags for the current issue slot and the last-row flag.
module serial_pe_ctrl_addr_gen
  import serial_pe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int VEC_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [VEC_W-1:0]  num_vec,
  input  logic              issue,
  input  logic              row_done,
  output logic [LEN_W-1:0]  elem,
  output logic [ADDR_W-1:0] w_addr,
  output logic              first,
  output logic              last,
  output logic              last_row
);

  logic [LEN_W-1:0]  vec_len_q;
  logic [VEC_W-1:0]  num_vec_q;
  logic [LEN_W-1:0]  elem_q;
  logic [VEC_W-1:0]  row_q;
  logic [ADDR_W-1:0] base_q;

  assign elem     = elem_q;
  assign first    = (elem_q == '0);
  assign last     = (elem_q == vec_len_q - LEN_W'(1));
  assign last_row = (row_q == num_vec_q - VEC_W'(1));
  // Base and offset both wrap modulo 2^ADDR_W.
  assign w_addr   = base_q + ADDR_W'(elem_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_len_q <= '0;
      num_vec_q <= '0;
      elem_q    <= '0;
      row_q     <= '0;
      base_q    <= '0;
    end else if (init) begin
      vec_len_q <= vec_len;
      num_vec_q <= num_vec;
      elem_q    <= '0;
      row_q     <= '0;
      base_q    <= '0;
    end else begin
      if (issue)
        elem_q <= last ? '0 : elem_q + LEN_W'(1);
      if (row_done) begin
        row_q  <= row_q + VEC_W'(1);
        base_q <= base_q + ADDR_W'(vec_len_q);
      end
    end
  end

endmodule

// File: rtl/serial_pe_ctrl.sv
// Sequencer for the serial MAC PE: streams neuron/weight pairs for each output row
// and parks every PE result in a one-entry valid/ready register.
module serial_pe_ctrl
  import serial_pe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int VEC_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_pe_ctrl_if.master  bus
);

  state_t               state_q, state_d;
  logic                 issue, capture, slot_free, args_ok, start_ok, start_zero;
  logic                 first, last, last_row;
  logic [LEN_W-1:0]     elem;
  logic [ADDR_W-1:0]    w_addr;
  logic                 pe_vld_q;
  logic [PE_CTL_W-1:0]  pe_ctl_q;
  logic [RES_W-1:0]     res_q;
  logic                 res_vld_q;
  logic                 done_q;

  assign args_ok    = (bus.vec_len != '0) && (bus.num_vec != '0);
  assign start_ok   = (state_q == IDLE) && bus.start && args_ok;
  assign start_zero = (state_q == IDLE) && bus.start && !args_ok;
  assign issue      = (state_q == ISSUE);
  assign capture    = (state_q == WAIT_RES) && bus.pe_vld_o;
  assign slot_free  = !res_vld_q || bus.res_rdy;

  serial_pe_ctrl_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .VEC_W  (VEC_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (start_ok),
    .vec_len  (bus.vec_len),
    .num_vec  (bus.num_vec),
    .issue    (issue),
    .row_done (capture),
    .elem     (elem),
    .w_addr   (w_addr),
    .first    (first),
    .last     (last),
    .last_row (last_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // WAIT_RES is only left once the PE has reported, so pe_vld is always low
  // during the pe_vld_o cycle and the PE accumulator clears between rows.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_ok) state_d = slot_free ? ISSUE : WAIT_SLOT;
      ISSUE:     if (last) state_d = WAIT_RES;
      WAIT_RES:  if (bus.pe_vld_o) state_d = last_row ? FIN : WAIT_SLOT;
      WAIT_SLOT: if (slot_free) state_d = ISSUE;
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign bus.n_rd_en   = issue;
  assign bus.w_rd_en   = issue;
  assign bus.n_addr    = issue ? ADDR_W'(elem) : '0;
  assign bus.w_addr    = issue ? w_addr : '0;
  assign bus.pe_neuron = bus.n_rdata;
  assign bus.pe_weight = bus.w_rdata;
  assign bus.pe_vld    = pe_vld_q;
  assign bus.pe_ctl    = pe_ctl_q;
  assign bus.res       = res_q;
  assign bus.res_vld   = res_vld_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;

  // Issue enable and flags delayed one cycle to line up with the buffer read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_vld_q <= 1'b0;
      pe_ctl_q <= '0;
    end else begin
      pe_vld_q               <= issue;
      pe_ctl_q               <= '0;
      pe_ctl_q[PE_CTL_FIRST] <= issue && first;
      pe_ctl_q[PE_CTL_LAST]  <= issue && last;
    end
  end

  // A capture beats a same-cycle pop; WAIT_SLOT keeps the two from colliding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else if (capture) begin
      res_q     <= bus.pe_result;
      res_vld_q <= 1'b1;
    end else if (res_vld_q && bus.res_rdy) begin
      res_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= (state_q == FIN) || start_zero;
  end

endmodule

// File: doc/serial_pe_ctrl.md
Name: serial_pe_ctrl

Overview:
- Upstream sequencer for the serial multiply-accumulate PE; runs one matrix-vector product.
- Streams neuron/weight pairs from two single-port read buffers with valid and first/last controls, one dot product per output neuron.
- Captures each PE result into a one-entry valid/ready output register.

Parameters:
- ADDR_W, 10, buffer address width.
- LEN_W, 8, width of vector-length field (elements per dot product).
- VEC_W, 8, width of output-vector-count field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- start  in  1  one-cycle launch pulse; ignored while busy.
- vec_len  in  LEN_W  elements per dot product; sampled at start.
- num_vec  in  VEC_W  number of dot products (weight rows); sampled at start.
- n_rd_en  out  1  neuron buffer read enable.
- n_addr  out  ADDR_W  neuron read address.
- n_rdata  in  16  neuron read data, valid 1 cycle after n_rd_en.
- w_rd_en  out  1  weight buffer read enable.
- w_addr  out  ADDR_W  weight read address.
- w_rdata  in  16  weight read data, valid 1 cycle after w_rd_en.
- pe_neuron  out  16  signed operand to PE (n_rdata passthrough).
- pe_weight  out  16  signed operand to PE (w_rdata passthrough).
- pe_vld  out  1  operand valid to PE; PE clears its accumulator when low.
- pe_ctl  out  2  bit0 = first element, bit1 = last element of a dot product.
- pe_result  in  32  PE accumulator output.
- pe_vld_o  in  1  PE result valid, 1 cycle after last element accepted.
- res  out  32  captured dot-product result.
- res_vld  out  1  result register full.
- res_rdy  in  1  consumer accepts res when res_vld & res_rdy.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after final result is captured.

Behaviour:
- Reset: FSM to IDLE; all counters 0. All outputs low: n_rd_en, w_rd_en, n_addr, w_addr, pe_vld, pe_ctl, res, res_vld, busy, done.
- FSM states: IDLE, ISSUE, WAIT_RES, WAIT_SLOT, FIN.
- IDLE:
  - start with vec_len != 0 and num_vec != 0: latch both, elem=0, row=0, waddr_base=0, busy=1, go to ISSUE (or WAIT_SLOT if res_vld & !res_rdy).
  - start with vec_len == 0 or num_vec == 0: no reads; done=1 next cycle; busy stays 0.
- ISSUE, one read pair per cycle:
  - n_rd_en = w_rd_en = 1; n_addr = elem; w_addr = waddr_base + elem.
  - Issue flags first = (elem == 0), last = (elem == vec_len-1).
  - elem increments; on last, go to WAIT_RES.
- Alignment: pe_vld and pe_ctl are the issue enable and flags registered by 1 cycle, matching read latency. pe_neuron/pe_weight are combinational passthrough of read data.
- Gap rule: pe_vld must be low for at least the cycle in which pe_vld_o is high, so the PE clears its accumulator between dot products. WAIT_RES guarantees this.
- WAIT_RES:
  - On pe_vld_o=1: res <= pe_result, res_vld <= 1, row++, waddr_base += vec_len.
  - If row was num_vec-1, go to FIN; else go to WAIT_SLOT.
- WAIT_SLOT: go to ISSUE in the same cycle the slot is empty or popping (res_vld==0 or res_rdy==1).
- Timing per row:
  - t: last issue.
  - t+1: pe_vld=1, pe_ctl=2'b10 (2'b11 if vec_len==1).
  - t+2: pe_vld_o=1.
  - t+3: res_vld=1, next row issue permitted.
  - Minimum period = vec_len+3 cycles.
- FIN: done=1 for one cycle, busy=0, back to IDLE. res_vld stays held until the consumer takes it.
- res_vld clears on res_vld & res_rdy unless a capture occurs the same cycle; capture wins, and the WAIT_SLOT gating makes that impossible.
- Address arithmetic wraps modulo 2^ADDR_W; no overflow flag.
- start while busy: ignored, no effect on counters.
- Reset mid-operation: immediate return to reset state. Any partially accumulated PE sum is discarded by the PE's own reset.

Decomposition:
- Shared package: FSM state encoding, PE_CTL_FIRST/PE_CTL_LAST bit indices, 16/32 operand/result width constants.
- One sub-module natural: serial_pe_ctrl_addr_gen (elem/row counters, waddr_base, first/last flags).
- FSM and result register stay in the top.

Test Plan:
- vec_len=4, num_vec=1, neurons {1,2,3,4}, weights {5,6,7,8}, res_rdy=1 -> res=70; pe_ctl: 01, 00, 00, 10; done 1 cycle after res_vld rises.
- vec_len=3, num_vec=2, neurons {1,-1,2}, weights rows {3,4,5},{-2,0,7} -> res 9 then 12; w_addr 0..2 then 3..5; n_addr 0..2 twice; pe_vld low ≥1 cycle between rows.
- Same as above with res_rdy=0 for 10 cycles after first res_vld -> no second-row issue until res_rdy=1; first res held stable at 9; second res=12.
- vec_len=1, num_vec=1, neuron -32768, weight -32768 -> pe_ctl=2'b11, res=32'h4000_0000.
- vec_len=0 start -> no rd_en, done pulse next cycle; start asserted while busy mid-row -> ignored, results unchanged.
- Assert rst_n low during ISSUE of row 1 -> all outputs 0 asynchronously; new start afterwards completes with correct results.
